// File: rtl/pc_pkg.sv
// Shared constants, next-PC select encoding and opcode decode helper for the IF-stage PC generator.
package pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_RECOV,
    SEL_JR,
    SEL_J,
    SEL_BR,
    SEL_SEQ
  } NEXTPC_SEL;

  // True when the opcode field names a conditional branch.
  function automatic logic is_cond_branch(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
           (op == OP_BGTZ) || (op == OP_REGIMM);
  endfunction

endpackage

// File: rtl/if_pc_predict_if.sv
// Fetch-side and ID-resolution signal bundle between the pipeline and the PC generator.
interface if_pc_predict_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic [31:0]      IF_instruction;
  logic             IFBranch;
  logic             nBranch;
  logic             J;
  logic             JR;
  logic [31:0]      rs;
  logic [25:0]      ID_jindex;
  logic [31:0]      PC;
  logic [31:0]      PC_plus_4;
  logic             predict_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output stall, IF_instruction, IFBranch, nBranch, J, JR, rs, ID_jindex,
    input  PC, PC_plus_4, predict_taken, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  stall, IF_instruction, IFBranch, nBranch, J, JR, rs, ID_jindex,
    output PC, PC_plus_4, predict_taken, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch, jump and register-jump target computation.
module pc_target_calc (
  input  logic [31:0] pc_plus_4,
  input  logic [31:0] instr,
  input  logic [31:0] id_pc4,
  input  logic [25:0] jindex,
  input  logic [31:0] rs,
  output logic [31:0] br_tgt,
  output logic [31:0] j_tgt,
  output logic [31:0] jr_tgt
);

  logic unused_bits;

  // Sign-extended word offset; the add wraps modulo 2^32.
  assign br_tgt = pc_plus_4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign j_tgt  = {id_pc4[31:28], jindex, 2'b00};
  assign jr_tgt = {rs[31:2], 2'b00};

  assign unused_bits = ^{instr[31:16], id_pc4[27:0], rs[1:0]};

endmodule

// File: rtl/if_pc_predict.sv
// IF-stage next-PC generator: static predict-taken, one-cycle ID redirect recovery, perf counters.
module if_pc_predict
  import pc_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  CNT_W    = 32
) (
  input  logic          clock,
  input  logic          reset,
  if_pc_predict_if.slave bus
);

  localparam logic [31:0]      BUBBLE_PC4 = RESET_PC + 32'd4;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [31:0]      pc_q;
  logic [31:0]      id_pc4_q;
  logic [31:0]      id_recov_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  logic [31:0] pc_plus_4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] next_pc;
  logic        if_flush;
  logic        br_taken;
  NEXTPC_SEL   sel;

  assign pc_plus_4 = pc_q + 32'd4;
  // A stall masks ID redirects since ID operands are not yet valid.
  assign if_flush  = !bus.stall && (bus.nBranch || bus.J || bus.JR);
  assign br_taken  = bus.IFBranch && !bus.stall && !if_flush;

  pc_target_calc u_tgt (
    .pc_plus_4 (pc_plus_4),
    .instr     (bus.IF_instruction),
    .id_pc4    (id_pc4_q),
    .jindex    (bus.ID_jindex),
    .rs        (bus.rs),
    .br_tgt    (br_tgt),
    .j_tgt     (j_tgt),
    .jr_tgt    (jr_tgt)
  );

  // Next-PC priority select.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus_4;
    if (reset)             sel = SEL_RESET;
    else if (bus.stall)    sel = SEL_HOLD;
    else if (bus.nBranch)  sel = SEL_RECOV;
    else if (bus.JR)       sel = SEL_JR;
    else if (bus.J)        sel = SEL_J;
    else if (bus.IFBranch) sel = SEL_BR;

    case (sel)
      SEL_RESET: next_pc = RESET_PC;
      SEL_HOLD:  next_pc = pc_q;
      SEL_RECOV: next_pc = id_recov_q;
      SEL_JR:    next_pc = jr_tgt;
      SEL_J:     next_pc = j_tgt;
      SEL_BR:    next_pc = br_tgt;
      SEL_SEQ:   next_pc = pc_plus_4;
      default:   next_pc = pc_plus_4;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      id_pc4_q         <= BUBBLE_PC4;
      id_recov_q       <= BUBBLE_PC4;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q <= next_pc;
      if (!bus.stall) begin
        // After an ID redirect the IF slot is squashed, so ID sees a bubble.
        id_pc4_q   <= if_flush ? BUBBLE_PC4 : pc_plus_4;
        id_recov_q <= if_flush ? BUBBLE_PC4 : pc_plus_4;
        if (br_taken && (branch_cnt_q != CNT_MAX))
          branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (bus.nBranch && (mispredict_cnt_q != CNT_MAX))
          mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.PC             = pc_q;
  assign bus.PC_plus_4      = pc_plus_4;
  assign bus.predict_taken  = br_taken && !reset;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/if_pc_predict.md
# if_pc_predict

IF-stage next-PC generator that consumes the ID-stage branch/jump resolution (`nBranch`, `J`, `JR`, `IF_Flush`, `rs`) and drives the fetch address. It statically predicts every fetched conditional branch as taken, which matches the ID-stage misprediction contract. It keeps the fall-through and ID-stage return addresses so that an ID redirect can recover in one cycle. It also counts fetched branches and mispredictions for performance monitoring.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `CNT_W`, 32, width of the performance counters
- `clock` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `stall` in 1: load-use hazard hold; PC and ID-side registers keep their values
- `IF_instruction` in 32: instruction word fetched at `PC` this cycle
- `IFBranch` in 1: fetched opcode is beq/bne/bgtz/blez/REGIMM
- `nBranch` in 1: ID branch was predicted taken but resolved not taken
- `J` in 1: ID instruction is j/jal
- `JR` in 1: ID instruction is jr/jalr
- `rs` in 32: forwarded rs value from ID (JR target)
- `ID_jindex` in 26: instr_index field of the ID instruction
- `PC` out 32: current fetch address
- `PC_plus_4` out 32: `PC`+4, passed to IF/ID for link and offset use
- `predict_taken` out 1: IF redirected to the branch target this cycle
- `branch_cnt` out CNT_W: fetched conditional branches, saturating
- `mispredict_cnt` out CNT_W: `nBranch` events, saturating

## Operation
- Target math: `br_tgt` = `PC`+4 + (sext(`IF_instruction[15:0]`)<<2), mod 2^32, with wrap allowed. `j_tgt` = {`id_pc4[31:28]`, `ID_jindex`, 2'b00}. `JR` target = {`rs[31:2]`, 2'b00}, so the low bits are forced to zero.
- Internal registers:
  - `id_pc4` is the PC+4 of the instruction now in ID.
  - `id_recov` is the fall-through address of the branch now in ID; it equals `id_pc4`, and is kept separate so the counter path stays independent.
  - Both load `PC_plus_4` when `stall`=0.
  - Both load `RESET_PC`+4 on reset or on the cycle after a redirect, which is the bubble.
- Next-PC priority, evaluated each cycle (highest first):
  1. `reset` → `RESET_PC`
  2. `stall` → hold `PC`. A stall masks ID redirects because the ID operands are not yet valid.
  3. `nBranch` → `id_recov`
  4. `JR` → `rs` target
  5. `J` → `j_tgt`
  6. `IFBranch` → `br_tgt`, with `predict_taken`=1
  7. otherwise `PC`+4
- When several of `nBranch`/`J`/`JR` are high, this is a protocol error. The priority order above still applies and no assertion fires in RTL.
- If an ID redirect (`IF_Flush` high) coincides with `IFBranch`, the redirect wins. In that case `predict_taken`=0 and `branch_cnt` does not increment, because the IF instruction is squashed.
- `branch_cnt` increments when `IFBranch` && !`stall` && !`IF_Flush`.
- `mispredict_cnt` increments when `nBranch` && !`stall`.
- Both counters saturate at all-ones.

## Timing
- Reset values:
  - `PC`=`RESET_PC`
  - `PC_plus_4`=`RESET_PC`+4
  - `predict_taken`=0
  - both counters 0
  - `id_pc4` = `id_recov` = `RESET_PC`+4
- `PC` updates on the rising edge. A redirect requested in cycle N is visible on `PC` in cycle N+1, with zero extra bubbles beyond the flushed IF slot.
- `predict_taken` and `PC_plus_4` are combinational from the current `PC` and inputs.
- Reset asserted mid-stall or mid-redirect overrides everything in the same edge.
- Back-to-back branches are handled: a branch predicted in cycle N and a misprediction of the previous branch in cycle N are resolved by the redirect winning. `id_recov` then loads the bubble value, not the squashed branch's PC+4.

## Structure
- Shared package `pc_pkg`:
  - `RESET_PC_DEFAULT`
  - opcode constants `OP_BEQ`=6'b000100, `OP_BNE`=6'b000101, `OP_BLEZ`=6'b000110, `OP_BGTZ`=6'b000111, `OP_REGIMM`=6'b000001
  - `NEXTPC_SEL` enum: RESET/HOLD/RECOV/JR/J/BR/SEQ
- One sub-module, `pc_target_calc`: purely combinational; computes `br_tgt`, `j_tgt`, `jr_tgt`.
- The priority mux, the registers and the counters stay in the top module.

## Test plan
- **Reset then run:** `reset`=1 for 2 cycles, then 3 plain instructions → `PC` = 0, 0, 4, 8, 0xC; counters 0.
- **Predict taken:** at `PC`=0x40, fetch beq with imm 0x0003 → next `PC`=0x50, `predict_taken`=1, `branch_cnt`=1.
- **Mispredict recovery:** the branch from the previous scenario reaches ID with `nBranch`=1 → next `PC`=0x44, `mispredict_cnt`=1.
- **Negative offset wrap:** at `PC`=0x0, imm 0xFFFE → `br_tgt`=0xFFFF_FFFC.
- **Jumps:**
  - `J` with `id_pc4`=0x1000_0008 and `ID_jindex`=0x0000100 → `PC`=0x1000_0400.
  - `JR` with `rs`=0x0000_2003 → `PC`=0x0000_2000.
- **Stall precedence:** `stall`=1 with `nBranch`=1 → `PC` holds and `mispredict_cnt` is unchanged. After `stall` drops with `nBranch` still 1 → recovery occurs.
